// File: rtl/scale_mod_unit.sv
`default_nettype none
// ============================================================================
// Module   : scale_mod_unit
// Purpose  : Per-element out = floor((a*t + bias)/q) mod q, bias = 0 or
//            floor(q/2). Input FIFO, valid/ready on both sides, q==0 flag,
//            one shared restoring shift-subtract divider used twice.
// Revision : 1.0 - initial release
// ============================================================================
module scale_mod_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           t,
  input  logic [WIDTH-1:0]           q,
  input  logic [WIDTH-1:0]           in_data_i,
  input  logic                       in_round_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic                       out_err_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int DW    = 2 * WIDTH + 1;
  localparam int NW    = $clog2(DW + 1);

  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [NW-1:0] C_LAST = NW'(DW - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_MOD  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  // FIFO storage: {round, data}
  logic [WIDTH:0]   mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_r;
  logic             rnd_r;
  logic [WIDTH-1:0] t_r;
  logic [WIDTH-1:0] q_r;
  logic [DW-1:0]    sh_r;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_r;
  logic [NW-1:0]    iter_r;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic [WIDTH:0]   head;
  logic [2*WIDTH-1:0] prod;
  logic [DW-1:0]    bias;
  logic [DW-1:0]    dividend;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_next;
  logic [DW-1:0]    sh_next;
  logic             q_zero;

  assign empty       = (count == '0);
  assign full        = (count == C_FULL);
  assign in_ready_o  = !full;
  assign push        = in_valid_i && !full;
  assign pop         = !empty && ((state == S_IDLE) || ((state == S_HOLD) && out_ready_i));
  assign head        = mem[rd_ptr];
  assign count_o     = count;
  assign out_valid_o = (state == S_HOLD);
  assign busy_o      = (state != S_IDLE) || !empty;

  // Product and rounding bias; the sum cannot overflow DW bits
  assign prod     = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, t_r};
  assign bias     = rnd_r ? {{(WIDTH+2){1'b0}}, q_r[WIDTH-1:1]} : '0;
  assign dividend = {1'b0, prod} + bias;

  // One restoring step: bring in the next dividend bit, subtract q if it fits.
  // With rem_r < q the difference also stays below q, so WIDTH bits suffice.
  assign trial    = {rem_r, sh_r[DW-1]};
  assign ge       = (trial >= {1'b0, q_r});
  assign diff     = trial - {1'b0, q_r};
  assign rem_next = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign sh_next  = {sh_r[DW-2:0], ge};
  assign q_zero   = (q_r == '0);

  // FIFO storage write; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_round_i, in_data_i};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control FSM and datapath: pop/latch, multiply, divide by q, reduce mod q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      a_r        <= '0;
      rnd_r      <= 1'b0;
      t_r        <= '0;
      q_r        <= '0;
      sh_r       <= '0;
      rem_r      <= '0;
      iter_r     <= '0;
      out_data_o <= '0;
      out_err_o  <= 1'b0;
    end else begin
      if (pop) begin
        a_r   <= head[WIDTH-1:0];
        rnd_r <= head[WIDTH];
        t_r   <= t;
        q_r   <= q;
      end
      case (state)
        S_IDLE: begin
          if (pop) state <= S_MUL;
        end
        S_MUL: begin
          sh_r   <= dividend;
          rem_r  <= '0;
          iter_r <= '0;
          state  <= S_DIV;
        end
        S_DIV: begin
          sh_r <= sh_next;
          if (iter_r == C_LAST) begin
            // sh_r now holds the full quotient; restart remainder for the mod pass
            rem_r  <= '0;
            iter_r <= '0;
            state  <= S_MOD;
          end else begin
            rem_r  <= rem_next;
            iter_r <= iter_r + NW'(1);
          end
        end
        S_MOD: begin
          sh_r  <= sh_next;
          rem_r <= rem_next;
          if (iter_r == C_LAST) begin
            out_data_o <= q_zero ? '0 : rem_next;
            out_err_o  <= q_zero;
            iter_r     <= '0;
            state      <= S_HOLD;
          end else begin
            iter_r <= iter_r + NW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready_i) state <= empty ? S_IDLE : S_MUL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_scale_mod_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_scale_mod_unit
// Purpose  : Directed self-checking bench for scale_mod_unit (WIDTH=8, DEPTH=4)
// Revision : 1.0 - initial release
// ============================================================================
module tb_scale_mod_unit;

  localparam int W = 8;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [W-1:0]   t = '0;
  logic [W-1:0]   q = '0;
  logic [W-1:0]   in_data_i = '0;
  logic           in_round_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [W-1:0]   out_data_o;
  logic           out_err_o;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic           busy_o;
  logic [$clog2(D):0] count_o;

  int errors = 0;
  int checks = 0;

  scale_mod_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .t(t), .q(q),
    .in_data_i(in_data_i), .in_round_i(in_round_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_data_o(out_data_o), .out_err_o(out_err_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  // Push one element; returns 1 time unit after the accepting edge
  task automatic push(input logic [W-1:0] d, input logic rnd);
    int n;
    n = 0;
    @(negedge clk);
    in_data_i  = d;
    in_round_i = rnd;
    in_valid_i = 1'b1;
    while (!in_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_timeout: in_ready_o=%b required 1", in_ready_o);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, then let the accept edge pass
  task automatic wait_result(input logic [W-1:0] exp_d, input logic exp_e,
                             input string name, output time seen);
    int n;
    n = 0;
    while (!out_valid_o && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    seen = $time;
    checks++;
    if (out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: out_valid_o=%b required 1", name, out_valid_o);
    end else begin
      checks++;
      if (out_data_o !== exp_d) begin
        errors++;
        $display("FAIL %s_data: got %0d required %0d", name, out_data_o, exp_d);
      end
      checks++;
      if (out_err_o !== exp_e) begin
        errors++;
        $display("FAIL %s_err: got %b required %b", name, out_err_o, exp_e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({out_valid_o, out_err_o, busy_o} !== 3'b000 || out_data_o !== '0 || count_o !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b err=%b busy=%b data=%0d count=%0d required all 0",
               out_valid_o, out_err_o, busy_o, out_data_o, count_o);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready_o);
    end
  endtask

  task automatic test_single_latency;
    time ts;
    t = 8'd2; q = 8'd17; out_ready_i = 1'b1;
    push(8'd10, 1'b0);
    checks++;
    if (count_o !== 3'd1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_after_push: count=%0d busy=%b required 1/1", count_o, busy_o);
    end
    for (int i = 1; i <= 36; i++) begin
      @(posedge clk);
      #1;
      if (i == 35) begin
        checks++;
        if (out_valid_o !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: out_valid_o=%b at cycle 35 required 0", out_valid_o);
        end
      end
      if (i == 36) begin
        checks++;
        if (out_valid_o !== 1'b1) begin
          errors++;
          $display("FAIL latency_36: out_valid_o=%b at cycle 36 required 1", out_valid_o);
        end
      end
    end
    wait_result(8'd1, 1'b0, "single", ts);
  endtask

  task automatic test_back_to_back;
    time t1, t2;
    t = 8'd4; q = 8'd17; out_ready_i = 1'b1;
    push(8'd15, 1'b0);
    push(8'd15, 1'b1);
    wait_result(8'd3, 1'b0, "b2b_trunc", t1);
    wait_result(8'd4, 1'b0, "b2b_round", t2);
    checks++;
    if ((t2 - t1) !== 64'd360) begin
      errors++;
      $display("FAIL b2b_spacing: got %0t required 360", t2 - t1);
    end
  endtask

  task automatic test_full_width;
    time ts;
    t = 8'd255; q = 8'd10; out_ready_i = 1'b1;
    push(8'd255, 1'b0);
    push(8'd255, 1'b1);
    wait_result(8'd2, 1'b0, "fw_trunc", ts);
    wait_result(8'd3, 1'b0, "fw_round", ts);
  endtask

  task automatic test_q_zero;
    time ts;
    t = 8'd3; q = 8'd0; out_ready_i = 1'b1;
    push(8'd7, 1'b0);
    @(posedge clk);
    #1;
    // Element already popped with q=0; new t/q must not disturb it
    t = 8'd2; q = 8'd17;
    push(8'd10, 1'b0);
    wait_result(8'd0, 1'b1, "qzero", ts);
    wait_result(8'd1, 1'b0, "after_qzero", ts);
  endtask

  task automatic test_backpressure;
    logic [W-1:0] din [6];
    logic [W-1:0] dexp [6];
    logic [2:0]   cexp [5];
    int n;
    time ts;
    din  = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd55, 8'd60};
    dexp = '{8'd4, 8'd1, 8'd5, 8'd3, 8'd2, 8'd4};
    cexp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    t = 8'd3; q = 8'd7; out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(din[i], 1'b0);
      checks++;
      if (count_o !== cexp[i]) begin
        errors++;
        $display("FAIL bp_count_push%0d: got %0d required %0d", i, count_o, cexp[i]);
      end
    end
    checks++;
    if (in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_ready: in_ready_o=%b required 0", in_ready_o);
    end
    n = 0;
    while (!out_valid_o && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== dexp[0]) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%0d required 1/%0d", k, out_valid_o, out_data_o, dexp[0]);
      end
    end
    fork
      begin
        push(din[5], 1'b0);
        checks++;
        if (count_o !== 3'd4) begin
          errors++;
          $display("FAIL bp_count_push5: got %0d required 4", count_o);
        end
      end
      begin
        out_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
          wait_result(dexp[k], 1'b0, $sformatf("bp_res%0d", k), ts);
        end
      end
    join
    checks++;
    if (count_o !== 3'd0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: count=%0d busy=%b required 0/0", count_o, busy_o);
    end
  endtask

  task automatic test_reset_mid;
    logic seen_valid;
    time ts;
    t = 8'd2; q = 8'd17; out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) push(8'd10, 1'b0);
    checks++;
    if (count_o !== 3'd3) begin
      errors++;
      $display("FAIL mid_queued: count=%0d required 3", count_o);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid_o, out_err_o, busy_o} !== 3'b000 || out_data_o !== '0 || count_o !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b err=%b busy=%b data=%0d count=%0d required all 0",
               out_valid_o, out_err_o, busy_o, out_data_o, count_o);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (out_valid_o) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_emit: saw out_valid_o=1 after reset required none");
    end
    push(8'd10, 1'b0);
    wait_result(8'd1, 1'b0, "mid_fresh", ts);
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_full_width();
    test_q_zero();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scale_mod_unit.md
Name: scale_mod_unit

Overview:
- Parametrised successor of the single-element scale-and-reduce processor.
- Computes out = floor((a*t + bias)/q) mod q per element. bias = 0 (truncate mode) or floor(q/2) (round mode), selected per element.
- Adds an input FIFO, valid/ready handshakes on both sides with output backpressure, divide-by-zero flagging and an integrated restoring divider. No external mu/du instances.
- Sits between the ciphertext coefficient stream and the next RNS/NTT stage.

Parameters:
- WIDTH, 32, coefficient, t and q width in bits (>=4).
- DEPTH, 4, input FIFO depth in entries (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- t  in  WIDTH  plaintext modulus, sampled at pop
- q  in  WIDTH  ciphertext modulus, sampled at pop
- in_data_i  in  WIDTH  input coefficient
- in_round_i  in  1  1 = round mode for this element, stored in FIFO with data
- in_valid_i  in  1  input valid
- in_ready_o  out  1  FIFO not full
- out_data_o  out  WIDTH  result
- out_err_o  out  1  result came from q==0
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accept
- busy_o  out  1  FSM not IDLE or FIFO non-empty
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; FSM = IDLE; all datapath registers zero.
  - out_data_o=0, out_err_o=0, out_valid_o=0, busy_o=0, count_o=0.
  - in_ready_o=1 once rst is low.
  - Reset mid-operation discards the in-flight element and all FIFO contents.
- FIFO:
  - Push when in_valid_i && in_ready_o. in_ready_o = (count_o != DEPTH).
  - Push and pop in the same cycle leaves count_o unchanged.
  - No push when full; data is held upstream.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop on next edge. Latch data, round bit, t and q. Go to MUL.
  - MUL: register P = data*t (2*WIDTH bits). D = P + (round ? q>>1 : 0), 2*WIDTH+1 bits, no overflow. Go to DIV.
  - DIV: restoring shift-subtract D / q, one quotient bit per cycle, 2*WIDTH+1 cycles. Quotient Q is 2*WIDTH+1 bits. Go to MOD.
  - MOD: restoring division of Q by q for 2*WIDTH+1 cycles; keep the remainder R (< q, fits WIDTH). Go to HOLD.
  - HOLD: out_data_o=R and out_valid_o=1, stable until out_ready_i.
    - On the accept edge, out_valid_o drops next cycle.
    - If the FIFO is non-empty, the pop happens on that same edge and the FSM goes directly to MUL. Otherwise go to IDLE.
- Latency:
  - Pop edge to out_valid_o high = 4*WIDTH+3 cycles (1 + 2*(2*WIDTH+1)).
  - Push into an idle, empty unit to out_valid_o = 4*WIDTH+4 cycles.
  - Sustained throughput with out_ready_i=1: one result per 4*WIDTH+4 cycles.
- q==0:
  - Divider iterations are not performed meaningfully; the result is forced to out_data_o=0 with out_err_o=1.
  - Same latency as a normal element.
  - out_err_o is otherwise 0 and is valid only with out_valid_o.
- t==0 or data==0: result 0, out_err_o=0.
- t and q changes while busy_o=1 do not affect the in-flight element (latched at pop). They do affect queued elements.
- Results leave in FIFO order; no reordering and no drops under backpressure.

Test Plan:
- WIDTH=8, t=2, q=17, data=10, truncate -> out_data_o=1, err=0. out_valid_o rises exactly 36 cycles after the push edge.
- WIDTH=8, t=4, q=17, data=15: truncate -> 3, round -> 4. Both pushed back-to-back; outputs appear in order, 36 cycles apart with out_ready_i=1.
- WIDTH=8, t=255, q=10, data=255: truncate -> 2, round -> 3. Covers the full-width product and the 2*WIDTH+1 dividend.
- q=0, data=7, t=3 -> out_data_o=0, out_err_o=1. The next element with q=17, t=2, data=10 -> 1, err=0.
- Hold out_ready_i=0 and push 6 elements with DEPTH=4:
  - in_ready_o drops after the FIFO fills (count_o=4).
  - out_data_o is held stable in HOLD.
  - Releasing out_ready_i drains all 6 results in order; count_o tracks each push and pop.
- Assert rst during DIV with 3 queued elements -> all outputs zero immediately, count_o=0. No result is emitted after release; a fresh push then completes normally.
